// File: rtl/draw_mole_pkg.sv
// Shared definitions for the whack-a-mole overlay stage: hole geometry,
// FSM state encoding and the hole-pick helper.
package draw_mole_pkg;

  typedef enum logic [1:0] {
    HIDDEN = 2'd0,
    UP     = 2'd1,
    HIT    = 2'd2
  } mole_state_t;

  localparam int          NUM_HOLES    = 9;
  localparam int          LFSR_W       = 8;
  localparam logic [10:0] HOLE_SIZE_D  = 11'd50;
  localparam logic [10:0] HOLE_X0_D    = 11'd185;
  localparam logic [10:0] HOLE_X1_D    = 11'd385;
  localparam logic [10:0] HOLE_X2_D    = 11'd585;
  localparam logic [10:0] HOLE_Y0_D    = 11'd135;
  localparam logic [10:0] HOLE_Y1_D    = 11'd285;
  localparam logic [10:0] HOLE_Y2_D    = 11'd435;

  // Fold a 4-bit random value onto 0..8 and never repeat the current hole.
  function automatic logic [3:0] pick_hole(input logic [3:0] rnd, input logic [3:0] cur);
    logic [3:0] v;
    v = rnd;
    if (v >= 4'd9) begin
      v = v - 4'd9;
    end else begin
      v = rnd;
    end
    if (v == cur) begin
      v = (v == 4'd8) ? 4'd0 : v + 4'd1;
    end else begin
      v = v;
    end
    return v;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seedable on reset.
module mole_lfsr
  import draw_mole_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              pclk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_r;
  logic              fb_s;

  assign fb_s = lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3];
  assign q    = lfsr_r;

  // Shift register, advancing every pixel clock.
  always_ff @(posedge pclk) begin
    if (rst) begin
      lfsr_r <= SEED;
    end else begin
      lfsr_r <= {lfsr_r[6:0], fb_s};
    end
  end

endmodule

// File: rtl/draw_mole.sv
// Whack-a-mole game FSM plus mole overlay; forwards the VGA timing bus
// with one cycle of latency.
module draw_mole
  import draw_mole_pkg::*;
#(
  parameter logic [10:0] HOLE_SIZE   = HOLE_SIZE_D,
  parameter logic [10:0] HOLE_X0     = HOLE_X0_D,
  parameter logic [10:0] HOLE_X1     = HOLE_X1_D,
  parameter logic [10:0] HOLE_X2     = HOLE_X2_D,
  parameter logic [10:0] HOLE_Y0     = HOLE_Y0_D,
  parameter logic [10:0] HOLE_Y1     = HOLE_Y1_D,
  parameter logic [10:0] HOLE_Y2     = HOLE_Y2_D,
  parameter logic [11:0] MOLE_CLR    = 12'h852,
  parameter logic [11:0] HIT_CLR     = 12'hF00,
  parameter int          UP_FRAMES   = 45,
  parameter int          DOWN_FRAMES = 30,
  parameter int          HIT_FRAMES  = 15,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        whack_valid,
  input  logic [3:0]  whack_hole,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        mole_up,
  output logic [3:0]  mole_hole,
  output logic        hit_out,
  output logic        miss_out
);

  localparam logic [15:0] UP_LAST   = 16'(UP_FRAMES - 1);
  localparam logic [15:0] DOWN_LAST = 16'(DOWN_FRAMES - 1);
  localparam logic [15:0] HIT_LAST  = 16'(HIT_FRAMES - 1);

  mole_state_t state_r, state_s, shadow_state_r;
  logic [15:0] cnt_r, cnt_s;
  logic [3:0]  hole_s, shadow_hole_r;
  logic        hit_s, miss_s;
  logic        vblnk_prev_r, frame_tick_s, whack_ok_s;
  logic [7:0]  lfsr_s;
  logic        lfsr_unused_s;
  logic [10:0] hole_x_s, hole_y_s;
  logic        inside_s;
  logic [11:0] pix_s;

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .pclk (pclk),
    .rst  (rst),
    .q    (lfsr_s)
  );

  assign lfsr_unused_s = ^lfsr_s[7:4];
  assign frame_tick_s  = vblnk_in & ~vblnk_prev_r;
  assign whack_ok_s    = whack_valid && (whack_hole < 4'd9) && (whack_hole == mole_hole);

  // Next-state logic; a correct whack outranks a simultaneous timeout.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    hole_s  = mole_hole;
    hit_s   = 1'b0;
    miss_s  = 1'b0;
    case (state_r)
      HIDDEN: begin
        if (frame_tick_s && (cnt_r == DOWN_LAST)) begin
          state_s = UP;
          cnt_s   = 16'd0;
          hole_s  = pick_hole(lfsr_s[3:0], mole_hole);
        end else if (frame_tick_s) begin
          cnt_s = cnt_r + 16'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      UP: begin
        if (whack_ok_s) begin
          state_s = HIT;
          cnt_s   = 16'd0;
          hit_s   = 1'b1;
        end else if (frame_tick_s && (cnt_r == UP_LAST)) begin
          state_s = HIDDEN;
          cnt_s   = 16'd0;
          miss_s  = 1'b1;
        end else if (frame_tick_s) begin
          cnt_s = cnt_r + 16'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      HIT: begin
        if (frame_tick_s && (cnt_r == HIT_LAST)) begin
          state_s = HIDDEN;
          cnt_s   = 16'd0;
        end else if (frame_tick_s) begin
          cnt_s = cnt_r + 16'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = HIDDEN;
        cnt_s   = 16'd0;
      end
    endcase
  end

  // FSM registers, event pulses and the per-frame display shadow.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r        <= HIDDEN;
      cnt_r          <= 16'd0;
      mole_hole      <= 4'd0;
      mole_up        <= 1'b0;
      hit_out        <= 1'b0;
      miss_out       <= 1'b0;
      vblnk_prev_r   <= 1'b0;
      shadow_state_r <= HIDDEN;
      shadow_hole_r  <= 4'd0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      mole_hole    <= hole_s;
      mole_up      <= (state_s == UP);
      hit_out      <= hit_s;
      miss_out     <= miss_s;
      vblnk_prev_r <= vblnk_in;
      // Shadow holds what was live during the frame just finished.
      if (frame_tick_s) begin
        shadow_state_r <= state_r;
        shadow_hole_r  <= mole_hole;
      end else begin
        shadow_state_r <= shadow_state_r;
        shadow_hole_r  <= shadow_hole_r;
      end
    end
  end

  // Map the shadow hole index (row*3+col) to its square's corner.
  always_comb begin
    hole_x_s = HOLE_X0;
    hole_y_s = HOLE_Y0;
    case (shadow_hole_r)
      4'd0, 4'd3, 4'd6: hole_x_s = HOLE_X0;
      4'd1, 4'd4, 4'd7: hole_x_s = HOLE_X1;
      4'd2, 4'd5, 4'd8: hole_x_s = HOLE_X2;
      default:          hole_x_s = HOLE_X0;
    endcase
    case (shadow_hole_r)
      4'd0, 4'd1, 4'd2: hole_y_s = HOLE_Y0;
      4'd3, 4'd4, 4'd5: hole_y_s = HOLE_Y1;
      4'd6, 4'd7, 4'd8: hole_y_s = HOLE_Y2;
      default:          hole_y_s = HOLE_Y0;
    endcase
  end

  assign inside_s = (hcount_in >= hole_x_s) && (hcount_in <= hole_x_s + HOLE_SIZE) &&
                    (vcount_in >= hole_y_s) && (vcount_in <= hole_y_s + HOLE_SIZE);

  // Pixel compositing, blanking first.
  always_comb begin
    pix_s = rgb_in;
    if (hblnk_in || vblnk_in) begin
      pix_s = 12'h000;
    end else if ((shadow_state_r == UP) && inside_s) begin
      pix_s = MOLE_CLR;
    end else if ((shadow_state_r == HIT) && inside_s) begin
      pix_s = HIT_CLR;
    end else begin
      pix_s = rgb_in;
    end
  end

  // One-cycle delay of the timing bus alongside the composited pixel.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= 11'd0;
      vcount_out <= 11'd0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'h000;
    end else begin
      hcount_out <= hcount_in;
      vcount_out <= vcount_in;
      hsync_out  <= hsync_in;
      hblnk_out  <= hblnk_in;
      vsync_out  <= vsync_in;
      vblnk_out  <= vblnk_in;
      rgb_out    <= pix_s;
    end
  end

endmodule

// File: tb/tb_draw_mole.sv
// Randomized bench for draw_mole against a frame-level behavioural model
// of the game (tick counting, hole choice, per-frame display).
module tb_draw_mole;

  localparam int HS    = 50;
  localparam int MOLEC = 12'h852;
  localparam int HITC  = 12'hF00;
  localparam int UPF   = 45;
  localparam int DNF   = 30;
  localparam int HTF   = 15;
  localparam int SEED  = 8'hA5;
  localparam int P_DOWN = 0, P_UP = 1, P_HIT = 2;
  localparam int CAP   = 80000;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_in, rgb_out;
  logic        whack_valid;
  logic [3:0]  whack_hole, mole_hole;
  logic        mole_up, hit_out, miss_out;

  always #5 pclk = ~pclk;

  draw_mole dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .whack_valid(whack_valid), .whack_hole(whack_hole),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .mole_up(mole_up), .mole_hole(mole_hole),
    .hit_out(hit_out), .miss_out(miss_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: game phase, ticks seen in that phase, and what the
  // screen shows during the current frame.
  int m_lfsr, m_prev, m_phase, m_ticks, m_hole, m_sh_phase, m_sh_hole;
  logic [11:0] e_rgb;
  logic [25:0] e_bus;
  logic        e_up, e_hit, e_miss;
  logic [3:0]  e_hole;
  int cycles = 0;

  function automatic int pick(input int l, input int cur);
    int r;
    r = (l % 16) % 9;
    if (r == cur) r = (r + 1) % 9;
    return r;
  endfunction

  function automatic bit in_sq(input int h, input int x, input int y);
    int x0, y0;
    x0 = 185 + 200 * (h % 3);
    y0 = 135 + 150 * (h / 3);
    return (x >= x0) && (x <= x0 + HS) && (y >= y0) && (y <= y0 + HS);
  endfunction

  task automatic model_update();
    bit tick;
    int fb;
    if (rst) begin
      m_lfsr = SEED; m_prev = 0; m_phase = P_DOWN; m_ticks = 0; m_hole = 0;
      m_sh_phase = P_DOWN; m_sh_hole = 0;
      e_rgb = 12'h000; e_bus = 26'd0; e_up = 1'b0; e_hit = 1'b0; e_miss = 1'b0; e_hole = 4'd0;
      return;
    end
    tick = vblnk_in && (m_prev == 0);
    e_bus = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in};
    if (hblnk_in || vblnk_in) e_rgb = 12'h000;
    else if (m_sh_phase == P_UP && in_sq(m_sh_hole, hcount_in, vcount_in)) e_rgb = 12'(MOLEC);
    else if (m_sh_phase == P_HIT && in_sq(m_sh_hole, hcount_in, vcount_in)) e_rgb = 12'(HITC);
    else e_rgb = rgb_in;
    if (tick) begin
      m_sh_phase = m_phase;
      m_sh_hole  = m_hole;
    end
    e_hit = 1'b0;
    e_miss = 1'b0;
    if (m_phase == P_DOWN) begin
      if (tick) m_ticks++;
      if (m_ticks == DNF) begin
        m_phase = P_UP; m_ticks = 0; m_hole = pick(m_lfsr, m_hole);
      end
    end else if (m_phase == P_UP) begin
      if (whack_valid && int'(whack_hole) == m_hole) begin
        e_hit = 1'b1; m_phase = P_HIT; m_ticks = 0;
      end else begin
        if (tick) m_ticks++;
        if (m_ticks == UPF) begin
          e_miss = 1'b1; m_phase = P_DOWN; m_ticks = 0;
        end
      end
    end else begin
      if (tick) m_ticks++;
      if (m_ticks == HTF) begin
        m_phase = P_DOWN; m_ticks = 0;
      end
    end
    e_up = (m_phase == P_UP);
    e_hole = 4'(m_hole);
    fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
    m_lfsr = ((m_lfsr << 1) & 8'hFE) | fb;
    m_prev = vblnk_in;
  endtask

  task automatic step();
    @(posedge pclk);
    model_update();
    @(negedge pclk);
    cycles++;
    chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
    chk("timing_bus", 32'({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}), 32'(e_bus));
    chk("mole_up", 32'(mole_up), 32'(e_up));
    chk("mole_hole", 32'(mole_hole), 32'(e_hole));
    chk("hit_out", 32'(hit_out), 32'(e_hit));
    chk("miss_out", 32'(miss_out), 32'(e_miss));
  endtask

  function automatic int edge_off();
    case ($urandom_range(0, 6))
      0: return -1;
      1: return 0;
      2: return 1;
      3: return HS - 1;
      4: return HS;
      5: return HS + 1;
      default: return int'($urandom_range(0, HS));
    endcase
  endfunction

  task automatic drive_pixel(input bit vb);
    int h;
    if ($urandom_range(0, 3) != 0) begin
      h = ($urandom_range(0, 1) == 1) ? m_sh_hole : int'($urandom_range(0, 8));
      hcount_in = 11'(185 + 200 * (h % 3) + edge_off());
      vcount_in = 11'(135 + 150 * (h / 3) + edge_off());
    end else begin
      hcount_in = 11'($urandom_range(0, 2047));
      vcount_in = 11'($urandom_range(0, 2047));
    end
    rgb_in   = 12'($urandom_range(0, 4095));
    hsync_in = 1'($urandom_range(0, 1));
    vsync_in = 1'($urandom_range(0, 1));
    hblnk_in = ($urandom_range(0, 7) == 0);
    vblnk_in = vb;
  endtask

  function automatic logic [3:0] wrong_hole();
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(9, 15));
    return 4'((m_hole + int'($urandom_range(1, 8))) % 9);
  endfunction

  int  moles = 0;
  int  pol = 0;
  bit  was_up = 1'b0;
  bit  coinc;
  int  last_hole = 0;
  int  nlow, nhigh, guard;

  initial begin
    rst = 1'b1; whack_valid = 1'b0; whack_hole = 4'd0;
    drive_pixel(1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("rst_zero", 32'(|{rgb_out, hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out,
                          vblnk_out, mole_up, mole_hole, hit_out, miss_out}), 32'd0);
    rst = 1'b0;

    while (moles < 200 && cycles < CAP) begin
      nlow  = int'($urandom_range(2, 3));
      nhigh = int'($urandom_range(1, 2));
      for (int i = 0; i < nlow + nhigh; i++) begin
        drive_pixel(i >= nlow);
        whack_valid = 1'b0;
        whack_hole  = 4'($urandom_range(0, 15));
        coinc = (pol == 2) && (m_phase == P_UP) && vblnk_in && (m_prev == 0) && (m_ticks == UPF - 1);
        if (m_phase == P_UP) begin
          if (coinc) begin
            whack_valid = 1'b1; whack_hole = 4'(m_hole);
          end else if (pol == 0 && $urandom_range(0, 15) == 0) begin
            whack_valid = 1'b1; whack_hole = 4'(m_hole);
          end else if ($urandom_range(0, 7) == 0) begin
            whack_valid = 1'b1; whack_hole = wrong_hole();
          end
        end else if ($urandom_range(0, 15) == 0) begin
          whack_valid = 1'b1;
          whack_hole = ($urandom_range(0, 1) == 1) ? 4'(m_hole) : 4'($urandom_range(0, 15));
        end
        step();
        if (coinc) begin
          chk("coinc_hit", 32'(hit_out), 32'd1);
          chk("coinc_miss", 32'(miss_out), 32'd0);
        end
        if (e_up && !was_up) begin
          moles++;
          pol = int'($urandom_range(0, 2));
          chk("hole_range", 32'(mole_hole <= 4'd8), 32'd1);
          chk("hole_repeat", 32'(int'(mole_hole) != last_hole), 32'd1);
          last_hole = int'(mole_hole);
        end
        was_up = e_up;
      end
    end
    chk("mole_budget", 32'(moles), 32'd200);
    whack_valid = 1'b0;

    // Run into an UP phase, then reset mid-frame.
    guard = 0;
    while (m_phase != P_UP && guard < 3000) begin
      drive_pixel((guard % 4) == 3);
      step();
      guard++;
    end
    chk("reach_up", 32'(mole_up), 32'd1);
    drive_pixel(1'b0);
    step();
    rst = 1'b1;
    drive_pixel(1'b0);
    step();
    chk("rst_mid_up", 32'(|{rgb_out, hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out,
                            vblnk_out, mole_up, mole_hole, hit_out, miss_out}), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive_pixel((i % 4) == 3);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
